// File: rtl/median_avg_engine.sv
`default_nettype none
//==============================================================================
//  Module      : median_avg_engine
//  Description : Synchronises an asynchronous sample strobe, filters samples
//                through an optional 3-tap median, collects DEPTH filtered
//                values into a circular buffer and publishes a saturated
//                block average with an acknowledged interrupt to the CPU.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
//  Ports
//    clk_i        in   system clock, rising edge
//    rst_i        in   asynchronous active-high reset
//    data_av_ai   in   asynchronous sample strobe (one sample per rising edge)
//    data_i       in   sample value, stable while data_av_ai is high
//    median_en_i  in   1 = 3-tap median, 0 = bypass
//    irq_ack_i    in   interrupt acknowledge
//    rd_addr_i    in   buffer readback address
//    rd_data_o    out  buffer readback data (1-cycle latency)
//    avg_o        out  last computed average (saturated to OUT_W bits)
//    avg_valid_o  out  an average has been computed since reset
//    irq_o        out  interrupt request (level)
//    overrun_o    out  sticky: a filtered value was dropped
//    fill_o       out  values collected in the current block
//==============================================================================
module median_avg_engine #(
    parameter int DATA_W      = 16,
    parameter int LOG2_DEPTH  = 3,
    parameter int OUT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  data_av_ai,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  median_en_i,
    input  logic                  irq_ack_i,
    input  logic [LOG2_DEPTH-1:0] rd_addr_i,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic [OUT_W-1:0]      avg_o,
    output logic                  avg_valid_o,
    output logic                  irq_o,
    output logic                  overrun_o,
    output logic [LOG2_DEPTH:0]   fill_o
);

    localparam int c_DEPTH = 1 << LOG2_DEPTH;
    localparam int c_SUM_W = DATA_W + LOG2_DEPTH;

    localparam logic [LOG2_DEPTH:0]   c_FILL_ONE  = 1;
    localparam logic [LOG2_DEPTH:0]   c_FILL_LAST = (LOG2_DEPTH+1)'(c_DEPTH - 1);
    localparam logic [LOG2_DEPTH-1:0] c_PTR_ONE   = 1;
    // Largest representable average, one bit wider than the mean so the
    // comparison also covers OUT_W == DATA_W.
    localparam logic [DATA_W:0]       c_AVG_MAX   = (DATA_W+1)'((64'd1 << OUT_W) - 64'd1);

    typedef enum logic [0:0] {
        ST_COLLECT  = 1'b0,
        ST_WAIT_ACK = 1'b1
    } state_t;

    //--------------------------------------------------------------------------
    // Strobe synchroniser and rising-edge detect. The edge register clears on
    // reset, so a strobe already high at reset release yields one sample.
    //--------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic                   w_sample_stb;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], data_av_ai};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_sample_stb = r_sync[SYNC_STAGES-1] & ~r_sync_d;

    //--------------------------------------------------------------------------
    // Sample window and median filter
    //--------------------------------------------------------------------------
    logic [DATA_W-1:0] r_w0;
    logic [DATA_W-1:0] r_w1;
    logic [1:0]        r_win_cnt;
    logic [DATA_W-1:0] r_med;
    logic              r_med_valid;

    logic [DATA_W-1:0] w_min_ab;
    logic [DATA_W-1:0] w_max_ab;
    logic [DATA_W-1:0] w_min_mc;
    logic [DATA_W-1:0] w_median;
    logic [DATA_W-1:0] w_med_next;
    logic              w_med_ok;

    assign w_min_ab   = (data_i < r_w0) ? data_i : r_w0;
    assign w_max_ab   = (data_i < r_w0) ? r_w0   : data_i;
    assign w_min_mc   = (w_max_ab < r_w1) ? w_max_ab : r_w1;
    assign w_median   = (w_min_ab < w_min_mc) ? w_min_mc : w_min_ab;
    assign w_med_next = median_en_i ? w_median : data_i;
    // The median needs two real history samples before it means anything.
    assign w_med_ok   = ~median_en_i | (r_win_cnt >= 2'd2);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_w0        <= '0;
            r_w1        <= '0;
            r_win_cnt   <= 2'd0;
            r_med       <= '0;
            r_med_valid <= 1'b0;
        end else begin
            r_med_valid <= 1'b0;
            if (w_sample_stb) begin
                r_w1        <= r_w0;
                r_w0        <= data_i;
                r_med       <= w_med_next;
                r_med_valid <= w_med_ok;
                if (r_win_cnt != 2'd3) begin
                    r_win_cnt <= r_win_cnt + 2'd1;
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Block FSM
    //--------------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;
    logic   w_accept;
    logic   w_block_done;
    logic   w_release;
    logic   w_drop;

    logic [LOG2_DEPTH:0] r_fill;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_block_done = 1'b0;
        w_release    = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                if (r_med_valid) begin
                    w_accept = 1'b1;
                    if (r_fill == c_FILL_LAST) begin
                        w_block_done = 1'b1;
                        w_state_next = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_ACK: begin
                // Nothing is accepted while the CPU owns the result, even in
                // the ack cycle itself.
                w_drop = r_med_valid;
                if (irq_ack_i) begin
                    w_release    = 1'b1;
                    w_state_next = ST_COLLECT;
                end
            end
            default: begin
                w_state_next = ST_COLLECT;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Accumulator, average and status
    //--------------------------------------------------------------------------
    logic [LOG2_DEPTH-1:0] r_wr_ptr;
    logic [c_SUM_W-1:0]    r_sum;
    logic [OUT_W-1:0]      r_avg;
    logic                  r_avg_valid;
    logic                  r_irq;
    logic                  r_overrun;

    logic [c_SUM_W-1:0]    w_sum_next;
    logic [DATA_W-1:0]     w_mean;
    logic [DATA_W:0]       w_mean_sat;

    // The average includes the value completing the block, so it is taken
    // from the post-add sum.
    assign w_sum_next = r_sum + {{LOG2_DEPTH{1'b0}}, r_med};
    assign w_mean     = w_sum_next[c_SUM_W-1:LOG2_DEPTH];
    assign w_mean_sat = ({1'b0, w_mean} > c_AVG_MAX) ? c_AVG_MAX : {1'b0, w_mean};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr    <= '0;
            r_sum       <= '0;
            r_fill      <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
            r_irq       <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                r_sum    <= w_sum_next;
                r_fill   <= r_fill + c_FILL_ONE;
            end
            if (w_block_done) begin
                r_avg       <= w_mean_sat[OUT_W-1:0];
                r_avg_valid <= 1'b1;
                r_irq       <= 1'b1;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
            // The write pointer is left alone so the next block continues
            // from where the previous one wrapped.
            if (w_release) begin
                r_irq  <= 1'b0;
                r_sum  <= '0;
                r_fill <= '0;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Sample buffer. Contents are not reset; only the readback port is.
    //--------------------------------------------------------------------------
    logic [DATA_W-1:0] r_buf [c_DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_buf[r_wr_ptr] <= r_med;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_buf[rd_addr_i];
        end
    end

    assign rd_data_o   = r_rd_data;
    assign avg_o       = r_avg;
    assign avg_valid_o = r_avg_valid;
    assign irq_o       = r_irq;
    assign overrun_o   = r_overrun;
    assign fill_o      = r_fill;

endmodule

`default_nettype wire

// File: doc/median_avg_engine.md
Name: median_avg_engine

Overview:
- Parametrised successor to the sample-capture, median, writer-FSM and averaging chain, collapsed into one self-contained engine.
- Synchronises an asynchronous data-available strobe and filters samples with an optional 3-tap median.
- Collects DEPTH filtered values into an internal circular buffer and produces a saturated average.
- Raises an interrupt to the PicoBlaze with ack handshake, overrun detection and random-access buffer readback.

Parameters:
- DATA_W, 16, sample width (unsigned).
- LOG2_DEPTH, 3, log2 of samples averaged per block; DEPTH = 2**LOG2_DEPTH, range 1..6.
- OUT_W, 8, average output width; OUT_W <= DATA_W.
- SYNC_STAGES, 2, synchroniser flops on data_av_ai, minimum 2.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- data_av_ai  in  1  asynchronous sample strobe; each rising edge is one sample.
- data_i  in  DATA_W  sample value; source holds it stable while data_av_ai is high.
- median_en_i  in  1  1 = 3-tap median, 0 = bypass.
- irq_ack_i  in  1  interrupt acknowledge from the CPU.
- rd_addr_i  in  LOG2_DEPTH  buffer readback address.
- rd_data_o  out  DATA_W  buffer readback data, 1-cycle latency.
- avg_o  out  OUT_W  last computed average.
- avg_valid_o  out  1  high once any average has been computed since reset.
- irq_o  out  1  interrupt request, level.
- overrun_o  out  1  sticky: a filtered value was dropped.
- fill_o  out  LOG2_DEPTH+1  values collected in the current block.

Behaviour:
- Reset: all outputs 0. Synchroniser, window, buffer pointers, sum and FSM are cleared (state COLLECT). Buffer contents are undefined.
- Sync: data_av_ai passes through SYNC_STAGES flops. A rising edge on the last stage gives a 1-cycle sample_stb, and data_i is captured on that cycle. If data_av_ai is high at reset release, exactly one strobe is produced.
- Window: w0 and w1 (previous two samples) plus a 2-bit sample count, saturating at 3. On sample_stb the window shifts in data_i.
- Median mode: med = median(data_i, w0, w1), unsigned, computed as max(min(a,b), min(max(a,b),c)). No med_valid until the 3rd sample after reset.
- Bypass mode: med = data_i for every sample.
- med_valid is registered and asserts 1 cycle after sample_stb.
- median_en_i changes take effect on the next sample_stb. Window contents are retained across the change.
- FSM states: COLLECT and WAIT_ACK.
- COLLECT, on med_valid:
  - buf[wr_ptr] <= med, wr_ptr++ (wraps mod DEPTH), sum += med (width DATA_W+LOG2_DEPTH), fill++.
  - When fill reaches DEPTH: on the next cycle avg_o <= min(sum >> LOG2_DEPTH, 2**OUT_W-1), avg_valid_o <= 1, irq_o <= 1, state <= WAIT_ACK.
- WAIT_ACK:
  - irq_o, avg_o and fill_o = DEPTH are held.
  - med_valid is dropped and sets overrun_o. A med_valid in the same cycle as irq_ack_i is also dropped.
  - On irq_ack_i = 1: the next cycle has irq_o = 0, sum = 0, fill = 0, state COLLECT. wr_ptr is not reset; the next block starts where the last one wrapped.
- overrun_o clears only on reset.
- Readback: rd_data_o <= buf[rd_addr_i] every cycle, independent of FSM state. Reading an address written in the same cycle returns the old data.
- irq_ack_i while in COLLECT is ignored.
- Reset mid-block discards the partial sum and drops irq_o asynchronously.

Test Plan:
- Bypass, defaults, samples 10,20,...,80 → 8 med_valid pulses. The cycle after the 8th: irq_o=1, avg_o=45, avg_valid_o=1, fill_o=8.
- Median mode, samples 50,50,1000,50,50,50,1000,50,50,50 → first med_valid on the 3rd sample; 8 medians all 50; avg_o=50, spikes rejected.
- Saturation: bypass, eight samples of 1024 → avg_o=0xFF. Readback rd_addr_i=0..7 gives 1024 each, 1 cycle after each address.
- Overrun: complete a block, withhold ack, send 3 samples → overrun_o=1, fill_o stays 8, avg_o unchanged. Pulse irq_ack_i → irq_o=0 next cycle, fill_o=0, overrun_o stays 1.
- Ack coincident with med_valid → that value is dropped, overrun_o=1, the next block starts from fill_o=0.
- Reset mid-block: after 5 bypass samples assert rst_i → all outputs 0 immediately. Then 8 samples of 100 → avg_o=100, irq_o=1.
